// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus iterative MULT/DIV engine with HI/LO and stall.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they run unsigned.
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic [3:0]       alu_ctrl_o,
  output logic             use_hilo_o,
  output logic [WIDTH-1:0] hilo_rdata_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opd_q, opd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 div_q, div_d;
  logic                 pneg_q, pneg_d;
  logic                 rneg_q, rneg_d;
  logic                 divz_q, divz_d;
  logic                 done_q, done_d;

  logic                 r_op, is_md, is_mfhi, is_mflo;
  logic                 start, signed_op, sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;

  assign r_op    = alu_op_i == 2'b10;
  assign is_md   = r_op & (funct_i[5:2] == 4'b0110);
  assign is_mfhi = r_op & (funct_i == 6'b010000);
  assign is_mflo = r_op & (funct_i == 6'b010010);
  assign start   = valid_i & is_md & (state_q == IDLE);

`ifdef MULDIV_SIGNED_EN
  assign signed_op = ~funct_i[0];
`else
  assign signed_op = 1'b0;
`endif

  assign sa    = signed_op & src_a_i[WIDTH-1];
  assign sb    = signed_op & src_b_i[WIDTH-1];
  assign mag_a = sa ? -src_a_i : src_a_i;
  assign mag_b = sb ? -src_b_i : src_b_i;

  always_comb begin
    alu_ctrl_o = 4'b0000;
    unique case (alu_op_i)
      2'b00: alu_ctrl_o = 4'b0010;
      2'b01: alu_ctrl_o = 4'b0110;
      2'b10: begin
        case (funct_i)
          6'b100000: alu_ctrl_o = 4'b0010;
          6'b100010: alu_ctrl_o = 4'b0110;
          6'b100100: alu_ctrl_o = 4'b0000;
          6'b100101: alu_ctrl_o = 4'b0001;
          6'b100111: alu_ctrl_o = 4'b1100;
          6'b101010: alu_ctrl_o = 4'b0111;
          default:   alu_ctrl_o = 4'b0000;
        endcase
      end
      2'b11: alu_ctrl_o = 4'b0000;
    endcase
  end

  // acc holds {partial, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opd_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    pneg_d  = pneg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = funct_i[1];
          opd_d   = funct_i[1] ? mag_b : mag_a;
          acc_d   = {{WIDTH{1'b0}},
                     (funct_i[1] ? mag_a : mag_b)};
          pneg_d  = sa ^ sb;
          rneg_d  = sa;
          divz_d  = src_b_i == '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          acc_d = div_diff[WIDTH]
            ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
            : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          lo_d = divz_q ? '1
               : pneg_q ? -acc_q[WIDTH-1:0]
               : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
               : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = pneg_q ? -acc_q : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      pneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      pneg_q  <= pneg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end

  assign busy_o       = state_q != IDLE;
  assign done_o       = done_q;
  assign use_hilo_o   = valid_i & (is_mfhi | is_mflo);
  assign hilo_rdata_o = !use_hilo_o ? '0
                      : is_mfhi ? hi_q : lo_q;
  assign stall_o      = valid_i & busy_o
                      & (is_md | is_mfhi | is_mflo);

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv: cycle model with countdown timer and
// arithmetic reference results, plus literal directed expectations.
module tb_alu_ctrl_muldiv;
  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic         valid  = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   funct  = 6'b0;
  logic [W-1:0] src_a  = '0;
  logic [W-1:0] src_b  = '0;
  logic [3:0]   alu_ctrl;
  logic         use_hilo;
  logic [W-1:0] hilo_rdata;
  logic         stall, busy, done;

  alu_ctrl_muldiv #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid),
    .alu_op_i     (alu_op),
    .funct_i      (funct),
    .src_a_i      (src_a),
    .src_b_i      (src_b),
    .alu_ctrl_o   (alu_ctrl),
    .use_hilo_o   (use_hilo),
    .hilo_rdata_o (hilo_rdata),
    .stall_o      (stall),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit f_md(logic [1:0] op, logic [5:0] f);
    return op == 2'b10 &&
      (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
  endfunction

  function automatic logic [3:0] exp_ctrl(logic [1:0] op,
                                          logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0000;
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  // {HI, LO} from plain 64-bit arithmetic
  function automatic logic [63:0] md_result(logic [5:0] f,
                                            logic [W-1:0] a,
                                            logic [W-1:0] b);
    bit sgn;
    longint sa, sb, q, r;
`ifdef MULDIV_SIGNED_EN
    sgn = !f[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!f[1]) return 64'(sa * sb);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  int           m_left = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;
  logic         m_done = 1'b0;
  logic [63:0]  m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (valid && f_md(alu_op, funct)) begin
        m_left = W + 1;
        m_pend = md_result(funct, src_a, src_b);
      end
    end
  end

  always @(negedge clk) begin
    logic         uh, st;
    logic [W-1:0] rd;
    uh = valid && alu_op == 2'b10 &&
         (funct == F_MFHI || funct == F_MFLO);
    rd = !uh ? '0 : (funct == F_MFHI ? m_hi : m_lo);
    st = valid && m_left != 0 &&
         (f_md(alu_op, funct) || uh);
    chk("alu_ctrl", 64'(alu_ctrl), 64'(exp_ctrl(alu_op, funct)));
    chk("busy", 64'(busy), 64'(m_left != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("use_hilo", 64'(use_hilo), 64'(uh));
    chk("hilo_rdata", 64'(hilo_rdata), 64'(rd));
    chk("stall", 64'(stall), 64'(st));
  end

  task automatic drive(input bit v, input logic [1:0] op,
                       input logic [5:0] f,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(posedge clk);
    #2;
    valid  = v;
    alu_op = op;
    funct  = f;
    src_a  = a;
    src_b  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 6'd0, '0, '0);
  endtask

  // waits out the MFHI/MFLO stall that was just issued; bounded
  task automatic wait_unstall(output int n);
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic md_check(input string nm, input logic [5:0] f,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] ehi,
                          input logic [W-1:0] elo);
    int n;
    drive(1'b1, 2'b10, f, a, b);
    drive(1'b1, 2'b10, F_MFHI, ~a, ~b);
    wait_unstall(n);
    chk({nm, "_stalls"}, 64'(n), 64'(W + 1));
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_hi"}, 64'(hilo_rdata), 64'(ehi));
    drive(1'b1, 2'b10, F_MFLO, a, b);
    @(negedge clk);
    chk({nm, "_lo"}, 64'(hilo_rdata), 64'(elo));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [5:0] flist [14] = '{
    6'b100000, 6'b100010, 6'b100100, 6'b100101,
    6'b100111, 6'b101010, F_MULT, F_MULTU, F_DIV,
    F_DIVU, F_MFHI, F_MFLO, 6'b111111, 6'b000000};

  initial begin
    int n, nd;
    #1 rst_n = 1'b0;
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = F_MFHI;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hilo_rdata), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    // decode sweep
    for (int op = 0; op < 4; op++)
      for (int i = 0; i < 14; i++)
        drive(1'b0, 2'(op), flist[i], '0, '0);
    drive(1'b1, 2'b10, F_NOR, '0, '0);
    @(negedge clk);
    chk("nor_ctrl", 64'(alu_ctrl), 64'hC);
    drive(1'b1, 2'b10, 6'b111111, '0, '0);
    @(negedge clk);
    chk("unk_ctrl", 64'(alu_ctrl), 64'h0);
    drive(1'b1, 2'b11, F_ADD, '0, '0);
    @(negedge clk);
    chk("op11_ctrl", 64'(alu_ctrl), 64'h0);

    md_check("multu", F_MULTU, 3, 5, 0, 15);
`ifdef MULDIV_SIGNED_EN
    md_check("mult", F_MULT, -32'sd7, 3,
             32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md_check("div", F_DIV, -32'sd7, 2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    md_check("mult", F_MULT, -32'sd7, 3,
             32'h0000_0002, 32'hFFFF_FFEB);
    md_check("div", F_DIV, -32'sd7, 2,
             32'h0000_0001, 32'h7FFF_FFFC);
`endif
    md_check("divu", F_DIVU, 100, 7, 2, 14);
    md_check("divz", F_DIVU, 9, 0, 9, 32'hFFFF_FFFF);

    // non-HI/LO instruction proceeds while busy
    drive(1'b1, 2'b10, F_MULTU, 4, 4);
    drive(1'b1, 2'b10, F_ADD, 1, 1);
    @(negedge clk);
    chk("add_busy", 64'(busy), 64'd1);
    chk("add_stall", 64'(stall), 64'd0);
    idle(40);

    // back-to-back: second accepted in the done cycle
    drive(1'b1, 2'b10, F_MULTU, 6, 7);
    drive(1'b1, 2'b10, F_MULTU, 2, 3);
    wait_unstall(n);
    chk("b2b_stalls", 64'(n), 64'(W + 1));
    chk("b2b_done", 64'(done), 64'd1);
    drive(1'b1, 2'b10, F_MFLO, 0, 0);
    wait_unstall(n);
    chk("b2b2_stalls", 64'(n), 64'(W + 1));
    chk("b2b2_lo", 64'(hilo_rdata), 64'd6);

    // reset in the middle of a divide
    drive(1'b1, 2'b10, F_DIV, 50, 3);
    idle(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = F_MFLO;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_lo", 64'(hilo_rdata), 64'd0);
    funct = F_MFHI;
    #1;
    chk("mid_rst_hi", 64'(hilo_rdata), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    valid = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no_done_after_rst", 64'(nd), 64'd0);
    md_check("post_rst", F_MULTU, 2, 2, 0, 4);

    // randomized traffic
    repeat (800) begin
      drive($urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0)
              ? 6'($urandom) : flist[$urandom_range(0, 13)],
            pick(), pick());
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
